issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Issue controller between instruction decode and execute in the in-order RISC-V core. Keeps a per-register pending-write scoreboard and gates each decoded instruction with a ready/valid handshake, stalling on RAW/WAW hazards. Serialises conditional branches: it holds issue until the branch resolves, then emits a one-cycle flush when the branch is taken. Optionally keeps a saturating stall-cycle counter.

## Interface
- NREG, 32, architectural register count (x0 hard-wired zero)
- RAW, 5, register index width, clog2(NREG)
- CNT_W, 16, stall counter width (used only with PERF macro)

- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  decode holds a valid instruction
- i_id_rs1 / i_id_rs2  in  RAW  source register indices
- i_id_use_rs1 / i_id_use_rs2  in  1  source actually read
- i_id_rd  in  RAW  destination index
- i_id_reg_write  in  1  instruction writes rd
- i_id_branch  in  1  instruction is a conditional branch (SB type)
- o_id_ready  out  1  issue permitted this cycle (combinational)
- o_issue  out  1  i_id_valid & o_id_ready
- i_wb_valid  in  1  write-back retiring a register write
- i_wb_rd  in  RAW  write-back destination
- i_br_resolve  in  1  branch outcome valid
- i_br_taken  in  1  outcome, qualified by i_br_resolve
- o_flush  out  1  registered, kill IF/ID contents
- o_busy  out  NREG  scoreboard, bit n = write to xn pending
- o_stall_cnt  out  CNT_W  stall cycles (PERF builds only, else absent)

## Operation
- FSM states: RUN, BR_WAIT, FLUSH. Reset state RUN.
- Hazard (RUN only): (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (reg_write & busy[rd]); index 0 never hazards.
- Same-cycle write-back bypass: a busy bit being cleared by i_wb_valid/i_wb_rd this cycle counts as not busy for the hazard check.
- o_id_ready = (state==RUN) & ~hazard. Ready does not depend on i_id_valid.
- On o_issue with reg_write and rd!=0: busy[rd] set at next edge.
- On i_wb_valid with wb_rd!=0: busy[wb_rd] cleared at next edge. Simultaneous set and clear of same index: set wins.
- x0: never set; busy[0] always 0.
- On o_issue with i_id_branch: RUN -> BR_WAIT.
- BR_WAIT: ready=0. On i_br_resolve: taken -> FLUSH, not taken -> RUN. i_br_resolve in RUN/FLUSH ignored.
- FLUSH: o_flush=1 for exactly that cycle, ready=0, -> RUN next edge. Scoreboard untouched by flush (nothing younger than branch was issued).
- Write-back continues clearing bits in all states.

## Timing
- Reset values: o_busy=0, o_flush=0, state RUN, o_stall_cnt=0; o_id_ready=1 once i_rst_n deasserted (no hazards).
- Reset asserted mid-branch or mid-stall: immediate return to reset values.
- Dependent instruction back-to-back: issue at cycle N sets busy at N+1; dependent stalls from N+1 until the write-back cycle, issues in that cycle via bypass.
- Branch taken, resolved cycle R: o_flush high in R+1, ready high again in R+2.
- Branch not taken, resolved cycle R: ready high in R+1.
- o_id_ready and o_issue combinational from inputs and registered state; o_flush registered.

## Configuration
- ISSUE_CTRL_PERF_EN defined: o_stall_cnt present; increments each cycle i_id_valid & ~o_id_ready, saturates at all-ones, cleared only by reset.
- Undefined: port and counter removed; all other behaviour identical.

## Structure
- Shared core package: FSM state enum (RUN/BR_WAIT/FLUSH), NREG/RAW constants, opcode macros already used by decode.
- One sub-module natural: issue_scoreboard (busy vector, set/clear priority, bypassed read for three ports). FSM and counter stay in top.

## Test plan
- Reset then idle: o_busy=0, o_flush=0, o_id_ready=1, o_stall_cnt=0.
- Issue add x5 at cycle 1, dependent sub rs1=x5 at cycle 2, wb x5 at cycle 6 -> ready low cycles 2-5, issue cycle 6, busy[5]=0 at cycle 7.
- Issue with rd=x0 reg_write=1 -> busy stays 0; dependent on x0 issues next cycle.
- Same cycle: wb x7 and issue rd=x7 -> busy[7]=1 next cycle.
- Branch issues cycle 3, resolve taken cycle 6 -> ready low cycles 4-7, o_flush=1 cycle 7 only, ready high cycle 8; not-taken variant -> ready high cycle 7, no flush.
- PERF build: hold hazard 70000 cycles -> o_stall_cnt saturates at 65535; assert i_rst_n low mid-stall -> counter and busy 0 immediately.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared core definitions for the issue stage: register-file geometry,
// issue FSM states and the opcode macros used by decode.
`ifndef ISSUE_CTRL_PKG_OPCODES
`define ISSUE_CTRL_PKG_OPCODES
`define RV_OPC_LUI    7'b0110111
`define RV_OPC_AUIPC  7'b0010111
`define RV_OPC_JAL    7'b1101111
`define RV_OPC_JALR   7'b1100111
`define RV_OPC_BRANCH 7'b1100011
`define RV_OPC_LOAD   7'b0000011
`define RV_OPC_STORE  7'b0100011
`define RV_OPC_OPIMM  7'b0010011
`define RV_OPC_OP     7'b0110011
`endif

package issue_ctrl_pkg;

  localparam int CORE_NREG = 32;
  localparam int CORE_RAW  = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with
// set-over-clear priority and write-back-bypassed lookups for rs1/rs2/rd.
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NREG = CORE_NREG,
  parameter int RAW  = CORE_RAW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [RAW-1:0]  set_idx,
  input  logic            clr_en,
  input  logic [RAW-1:0]  clr_idx,
  input  logic [RAW-1:0]  rs1_idx,
  input  logic [RAW-1:0]  rs2_idx,
  input  logic [RAW-1:0]  rd_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A bit being retired by write-back this cycle already reads as free.
  assign rs1_busy = (rs1_idx != '0) & busy_q[rs1_idx] & ~(clr_en & (clr_idx == rs1_idx));
  assign rs2_busy = (rs2_idx != '0) & busy_q[rs2_idx] & ~(clr_en & (clr_idx == rs2_idx));
  assign rd_busy  = (rd_idx  != '0) & busy_q[rd_idx]  & ~(clr_en & (clr_idx == rd_idx));

  assign busy = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: hazard-gated ready/valid issue, branch serialisation with
// one-cycle flush. Define ISSUE_CTRL_PERF_EN to add the saturating stall counter.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int NREG  = CORE_NREG,
  parameter int RAW   = CORE_RAW
`ifdef ISSUE_CTRL_PERF_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_id_valid,
  input  logic [RAW-1:0]  i_id_rs1,
  input  logic [RAW-1:0]  i_id_rs2,
  input  logic            i_id_use_rs1,
  input  logic            i_id_use_rs2,
  input  logic [RAW-1:0]  i_id_rd,
  input  logic            i_id_reg_write,
  input  logic            i_id_branch,
  output logic            o_id_ready,
  output logic            o_issue,
  input  logic            i_wb_valid,
  input  logic [RAW-1:0]  i_wb_rd,
  input  logic            i_br_resolve,
  input  logic            i_br_taken,
  output logic            o_flush,
  output logic [NREG-1:0] o_busy
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  issue_state_e state_q, state_d;
  logic         flush_q, flush_d;
  logic         rs1_busy, rs2_busy, rd_busy;
  logic         hazard;

  issue_scoreboard #(
    .NREG (NREG),
    .RAW  (RAW)
  ) u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .set_en   (o_issue & i_id_reg_write),
    .set_idx  (i_id_rd),
    .clr_en   (i_wb_valid),
    .clr_idx  (i_wb_rd),
    .rs1_idx  (i_id_rs1),
    .rs2_idx  (i_id_rs2),
    .rd_idx   (i_id_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .busy     (o_busy)
  );

  assign hazard     = (i_id_use_rs1 & rs1_busy) | (i_id_use_rs2 & rs2_busy) |
                      (i_id_reg_write & rd_busy);
  assign o_id_ready = (state_q == RUN) & ~hazard;
  assign o_issue    = i_id_valid & o_id_ready;
  assign o_flush    = flush_q;

  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    case (state_q)
      RUN: begin
        if (o_issue && i_id_branch) state_d = BR_WAIT;
      end
      BR_WAIT: begin
        if (i_br_resolve) begin
          state_d = i_br_taken ? FLUSH : RUN;
          flush_d = i_br_taken;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

`ifdef ISSUE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_id_valid && !o_id_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: per-cycle reference model plus directed
// literal checks; covers the stall counter when ISSUE_CTRL_PERF_EN is defined.
module tb_issue_ctrl;

  localparam int NREG  = 32;
  localparam int RAW   = 5;
  localparam int CNT_W = 16;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic            i_clk, i_rst_n;
  logic            i_id_valid, i_id_use_rs1, i_id_use_rs2, i_id_reg_write, i_id_branch;
  logic [RAW-1:0]  i_id_rs1, i_id_rs2, i_id_rd, i_wb_rd;
  logic            i_wb_valid, i_br_resolve, i_br_taken;
  logic            o_id_ready, o_issue, o_flush;
  logic [NREG-1:0] o_busy;
`ifdef ISSUE_CTRL_PERF_EN
  logic [CNT_W-1:0] o_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  issue_ctrl dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_id_valid     (i_id_valid),
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_use_rs1   (i_id_use_rs1),
    .i_id_use_rs2   (i_id_use_rs2),
    .i_id_rd        (i_id_rd),
    .i_id_reg_write (i_id_reg_write),
    .i_id_branch    (i_id_branch),
    .o_id_ready     (o_id_ready),
    .o_issue        (o_issue),
    .i_wb_valid     (i_wb_valid),
    .i_wb_rd        (i_wb_rd),
    .i_br_resolve   (i_br_resolve),
    .i_br_taken     (i_br_taken),
    .o_flush        (o_flush),
    .o_busy         (o_busy)
`ifdef ISSUE_CTRL_PERF_EN
    ,
    .o_stall_cnt    (o_stall_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending-write set, branch-outstanding flag, flush-this-cycle flag.
  bit          mb [NREG];
  bit          br_out, flush_now;
  int unsigned m_cnt;
  bit          m_rdy, m_iss;

  function automatic bit m_pending(input logic [RAW-1:0] idx);
    return (idx != 0) && mb[idx] && !(i_wb_valid && (i_wb_rd == idx));
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = (i_id_use_rs1 && m_pending(i_id_rs1)) || (i_id_use_rs2 && m_pending(i_id_rs2)) ||
          (i_id_reg_write && m_pending(i_id_rd));
    return !br_out && !flush_now && !haz;
  endfunction

  function automatic logic [NREG-1:0] m_busy_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = mb[i];
    return v;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) mb[i] = 1'b0;
      br_out = 1'b0; flush_now = 1'b0; m_cnt = 0;
    end else begin
      m_rdy = m_ready();
      m_iss = i_id_valid && m_rdy;
      if (i_id_valid && !m_rdy && m_cnt < CNT_MAX) m_cnt++;
      if (flush_now) flush_now = 1'b0;
      else if (br_out) begin
        if (i_br_resolve) begin
          br_out = 1'b0;
          flush_now = i_br_taken;
        end
      end else if (m_iss && i_id_branch) br_out = 1'b1;
      if (i_wb_valid && i_wb_rd != 0) mb[i_wb_rd] = 1'b0;
      if (m_iss && i_id_reg_write && i_id_rd != 0) mb[i_id_rd] = 1'b1;
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("m_rst_busy", o_busy, '0);
      chk("m_rst_flush", o_flush, 0);
    end else begin
      chk("m_busy", o_busy, m_busy_vec());
      chk("m_ready", o_id_ready, m_ready());
      chk("m_issue", o_issue, i_id_valid & m_ready());
      chk("m_flush", o_flush, flush_now);
`ifdef ISSUE_CTRL_PERF_EN
      chk("m_stall_cnt", o_stall_cnt, m_cnt);
`endif
    end
  end

  task automatic next();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit br);
    i_id_valid = v; i_id_rs1 = RAW'(rs1); i_id_use_rs1 = u1;
    i_id_rs2 = RAW'(rs2); i_id_use_rs2 = u2; i_id_rd = RAW'(rd);
    i_id_reg_write = rw; i_id_branch = br;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input bit v, input int rd);
    i_wb_valid = v; i_wb_rd = RAW'(rd);
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle(); wb(0, 0);
    i_br_resolve = 1'b0; i_br_taken = 1'b0;
    repeat (2) next();
    chk("rst_busy", o_busy, '0);
    chk("rst_flush", o_flush, 0);
    i_rst_n = 1'b1;
    #1;
    chk("idle_ready", o_id_ready, 1);
`ifdef ISSUE_CTRL_PERF_EN
    chk("idle_cnt", o_stall_cnt, 0);
`endif
    next();

    // RAW stall on x5 released by same-cycle write-back
    set_id(1, 1, 1, 2, 1, 5, 1, 0); #1;
    chk("add_issue", o_issue, 1);
    next();
    set_id(1, 5, 1, 6, 0, 6, 1, 0);
    for (int c = 0; c < 4; c++) begin
      #1; chk("dep_stall", o_id_ready, 0); chk("dep_busy", o_busy, 32'h20);
      next();
    end
    wb(1, 5); #1;
    chk("dep_bypass_ready", o_id_ready, 1);
    chk("dep_bypass_issue", o_issue, 1);
    next();
    idle(); wb(1, 6); #1;
    chk("x5_cleared", o_busy, 32'h40);
    next();
    wb(0, 0); #1;
    chk("all_clear", o_busy, '0);

    // x0 never becomes busy
    set_id(1, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("x0_issue", o_issue, 1);
    next();
    #1; chk("x0_busy", o_busy, '0);
    set_id(1, 0, 1, 0, 1, 0, 1, 0); #1;
    chk("x0_dep_ready", o_id_ready, 1);
    next();

    // WAW on x7 with simultaneous write-back: set wins
    set_id(1, 0, 0, 0, 0, 7, 1, 0);
    next();
    set_id(1, 0, 0, 0, 0, 7, 1, 0); wb(1, 7); #1;
    chk("waw_bypass_ready", o_id_ready, 1);
    next();
    idle(); wb(0, 0); #1;
    chk("set_wins", o_busy, 32'h80);
    wb(1, 7);
    next();
    wb(0, 0); #1;
    chk("x7_clear", o_busy, '0);

    // taken branch, write-back still retires during BR_WAIT
    set_id(1, 0, 0, 0, 0, 9, 1, 0);
    next();
    set_id(1, 1, 1, 0, 0, 0, 0, 1); #1;
    chk("br_issue", o_issue, 1);
    next();
    set_id(1, 2, 1, 3, 1, 10, 1, 0); wb(1, 9); #1;
    chk("brw_ready_c4", o_id_ready, 0);
    chk("brw_issue_c4", o_issue, 0);
    next();
    wb(0, 0); #1;
    chk("brw_ready_c5", o_id_ready, 0);
    chk("brw_wb_clear", o_busy, '0);
    next();
    i_br_resolve = 1'b1; i_br_taken = 1'b1; #1;
    chk("res_ready", o_id_ready, 0);
    chk("res_noflush", o_flush, 0);
    next();
    i_br_resolve = 1'b0; i_br_taken = 1'b0; #1;
    chk("flush_high", o_flush, 1);
    chk("flush_ready", o_id_ready, 0);
    next();
    #1;
    chk("post_flush", o_flush, 0);
    chk("post_flush_ready", o_id_ready, 1);
    next();
    idle(); wb(1, 10);
    next();
    wb(0, 0);

    // not-taken branch
    set_id(1, 0, 0, 0, 0, 0, 0, 1);
    next();
    set_id(1, 2, 1, 0, 0, 11, 1, 0); #1;
    chk("nt_wait_ready", o_id_ready, 0);
    next();
    i_br_resolve = 1'b1; i_br_taken = 1'b0; #1;
    chk("nt_res_ready", o_id_ready, 0);
    next();
    i_br_resolve = 1'b0; idle(); #1;
    chk("nt_ready", o_id_ready, 1);
    chk("nt_noflush", o_flush, 0);
    next();

    // resolve outside BR_WAIT is ignored
    i_br_resolve = 1'b1; i_br_taken = 1'b1;
    next();
    i_br_resolve = 1'b0; i_br_taken = 1'b0; #1;
    chk("ign_flush", o_flush, 0);
    chk("ign_ready", o_id_ready, 1);

    // reset mid-branch
    set_id(1, 0, 0, 0, 0, 0, 0, 1);
    next();
    idle(); #1;
    chk("mb_wait", o_id_ready, 0);
    i_rst_n = 1'b0; #1;
    chk("mb_rst_ready", o_id_ready, 1);
    chk("mb_rst_flush", o_flush, 0);
    next();
    i_rst_n = 1'b1;
    next();

    // reset mid-stall
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    next();
    set_id(1, 3, 1, 0, 0, 4, 1, 0); #1;
    chk("ms_stall", o_id_ready, 0);
    next();
    i_rst_n = 1'b0; #1;
    chk("ms_rst_busy", o_busy, '0);
    next();
    i_rst_n = 1'b1; idle(); #1;
    chk("ms_ready", o_id_ready, 1);
    chk("ms_busy", o_busy, '0);
    next();

`ifdef ISSUE_CTRL_PERF_EN
    set_id(1, 0, 0, 0, 0, 3, 1, 0);
    next();
    set_id(1, 3, 1, 0, 0, 4, 1, 0);
    #1; chk("cnt_start", o_stall_cnt, 0);
    next();
    #1; chk("cnt_one", o_stall_cnt, 1);
    repeat (70000) next();
    chk("cnt_sat", o_stall_cnt, 16'hFFFF);
    i_rst_n = 1'b0; #1;
    chk("cnt_rst", o_stall_cnt, 0);
    chk("cnt_rst_busy", o_busy, '0);
    next();
    i_rst_n = 1'b1; idle();
    next();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
